// File: rtl/cmp_result_stats.sv
// cmp_result_stats
//   Consumer of the 4-bit magnitude comparator's {gt,eq,lt} result code.
//   It accepts results on a valid/ready handshake and keeps saturating tallies of:
//   - greater / equal / less outcomes;
//   - illegal (non-one-hot) codes.
//   It also holds the last legal code and a sticky saturation flag.
//
// Optional feature macro: CMP_RUN_LEN_EN
//   Defined   : run_len counts consecutive identical legal results.
//   Undefined : run_len is tied to zero and no run logic is built.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   in_valid : comparator result valid
//   in_ready : result can be accepted this cycle (combinational)
//   y        : result code {gt,eq,lt}
//   clear    : synchronous clear of all tallies
//   freeze   : hold tallies and refuse results while high
//   gt_cnt   : accepted 100 codes
//   eq_cnt   : accepted 010 codes
//   lt_cnt   : accepted 001 codes
//   err_cnt  : accepted non-one-hot codes
//   last_y   : most recent legal code (000 = none since reset/clear)
//   sat      : sticky flag, set once some counter reaches its maximum
//   run_len  : consecutive identical legal results
module cmp_result_stats #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       y,
  input  logic             clear,
  input  logic             freeze,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       last_y,
  output logic             sat,
  output logic [CNT_W-1:0] run_len
);

  typedef enum logic [1:0] {RUN, HOLD, CLR} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // One below maximum: an increment from here or above lands on the maximum.
  localparam logic [CNT_W-1:0] CNT_NEAR = {{(CNT_W-1){1'b1}}, 1'b0};

  state_t state;
  logic   accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic hits_max(input logic [CNT_W-1:0] v);
    return v >= CNT_NEAR;
  endfunction

  assign in_ready = (state == RUN) && !clear && !freeze;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      lt_cnt  <= '0;
      err_cnt <= '0;
      last_y  <= 3'b000;
      sat     <= 1'b0;
`ifdef CMP_RUN_LEN_EN
      run_len <= '0;
`endif
    end else if (clear) begin
      // Clear wins over freeze; a beat offered now is refused via in_ready.
      state   <= CLR;
      gt_cnt  <= '0;
      eq_cnt  <= '0;
      lt_cnt  <= '0;
      err_cnt <= '0;
      last_y  <= 3'b000;
      sat     <= 1'b0;
`ifdef CMP_RUN_LEN_EN
      run_len <= '0;
`endif
    end else begin
      case (state)
        RUN:     if (freeze) state <= HOLD;
        HOLD:    if (!freeze) state <= RUN;
        CLR:     state <= freeze ? HOLD : RUN;
        default: state <= RUN;
      endcase

      if (accept) begin
        case (y)
          3'b100: begin
            gt_cnt <= sat_inc(gt_cnt);
            if (hits_max(gt_cnt)) sat <= 1'b1;
          end
          3'b010: begin
            eq_cnt <= sat_inc(eq_cnt);
            if (hits_max(eq_cnt)) sat <= 1'b1;
          end
          3'b001: begin
            lt_cnt <= sat_inc(lt_cnt);
            if (hits_max(lt_cnt)) sat <= 1'b1;
          end
          default: begin
            err_cnt <= sat_inc(err_cnt);
            if (hits_max(err_cnt)) sat <= 1'b1;
          end
        endcase

        if ((y == 3'b100) || (y == 3'b010) || (y == 3'b001)) begin
          last_y <= y;
`ifdef CMP_RUN_LEN_EN
          // last_y is 000 after reset/clear, so the first legal code restarts at 1.
          if (y == last_y) begin
            run_len <= sat_inc(run_len);
            if (hits_max(run_len)) sat <= 1'b1;
          end else begin
            run_len <= CNT_ONE;
          end
`endif
        end else begin
`ifdef CMP_RUN_LEN_EN
          run_len <= '0;
`endif
        end
      end
    end
  end

`ifndef CMP_RUN_LEN_EN
  assign run_len = '0;
`endif

endmodule
